// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock supervisor in the reference-clock domain.
// Retries lock acquisition, qualifies stable lock, then releases the pixel-domain reset.
module pll_lock_supervisor #(
   parameter int unsigned PLL_RST_CYCLES      = 16,
   parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
   parameter int unsigned MAX_RETRIES         = 4
) (
   input  logic       refclk_i,
   input  logic       rst_ni,
   input  logic       pll_locked_i,
   input  logic       relock_req_i,
   output logic       pll_rst_o,
   output logic       pix_rst_n_o,
   output logic       ready_o,
   output logic       fail_o,
   output logic [3:0] retry_cnt_o,
   output logic [7:0] lock_loss_cnt_o
);

   localparam int unsigned MaxAB = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                   PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
   localparam int unsigned MaxCycles = (MaxAB > LOCK_TIMEOUT_CYCLES) ? MaxAB : LOCK_TIMEOUT_CYCLES;
   localparam int unsigned CntW = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

   localparam logic [CntW-1:0] RstLast    = CntW'(PLL_RST_CYCLES - 1);
   localparam logic [CntW-1:0] StableLast = CntW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CntW-1:0] CntMax     = {CntW{1'b1}};
   localparam logic [3:0]      RetryLimit = 4'(MAX_RETRIES);

   typedef enum logic [2:0] {
      StPllRst,
      StWait,
      StStable,
      StRun,
      StFail
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [3:0]      retry_q, retry_d;
   logic [7:0]      loss_q, loss_d;
   logic [1:0]      sync_q;
   logic            locked_s;

   logic pll_rst_q, pll_rst_d;
   logic pix_rst_n_q, pix_rst_n_d;
   logic ready_q, ready_d;
   logic fail_q, fail_d;

   assign locked_s = sync_q[1];

   // State register, counters and lock synchroniser
   always_ff @(posedge refclk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StPllRst;
         cnt_q   <= '0;
         retry_q <= '0;
         loss_q  <= '0;
         sync_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         retry_q <= retry_d;
         loss_q  <= loss_d;
         sync_q  <= {sync_q[0], pll_locked_i};
      end
   end

   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      loss_d  = loss_q;
      case (state_q)
         StPllRst: begin
            if (cnt_q == RstLast) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (locked_s) begin
               state_d = StStable;
            end else if (cnt_q == TimeoutLast) begin
               retry_d = retry_q + 4'd1;
               state_d = (retry_d == RetryLimit) ? StFail : StPllRst;
            end
         end
         StStable: begin
            if (!locked_s) begin
               state_d = StWait;
            end else if (cnt_q == StableLast) begin
               state_d = StRun;
               retry_d = '0;
            end
         end
         StRun: begin
            // Lock loss takes priority over a simultaneous relock request so it is counted
            if (!locked_s) begin
               state_d = StPllRst;
               if (loss_q != 8'hFF) begin
                  loss_d = loss_q + 8'd1;
               end
            end else if (relock_req_i) begin
               state_d = StPllRst;
            end
         end
         StFail: begin
            if (relock_req_i) begin
               state_d = StPllRst;
               retry_d = '0;
            end
         end
         default: state_d = StPllRst;
      endcase

      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (cnt_q != CntMax) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Outputs decode the next state so they move on the same edge as the state
   always_comb begin
      pll_rst_d   = (state_d == StPllRst);
      pix_rst_n_d = (state_d == StRun);
      ready_d     = (state_d == StRun);
      fail_d      = (state_d == StFail);
   end

   always_ff @(posedge refclk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pll_rst_q   <= 1'b1;
         pix_rst_n_q <= 1'b0;
         ready_q     <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         pll_rst_q   <= pll_rst_d;
         pix_rst_n_q <= pix_rst_n_d;
         ready_q     <= ready_d;
         fail_q      <= fail_d;
      end
   end

   assign pll_rst_o       = pll_rst_q;
   assign pix_rst_n_o     = pix_rst_n_q;
   assign ready_o         = ready_q;
   assign fail_o          = fail_q;
   assign retry_cnt_o     = retry_q;
   assign lock_loss_cnt_o = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed scenarios plus randomized lock/relock
// stimulus checked against a timestamp-based behavioural model.
module tb_pll_lock_supervisor;

   localparam int PR = 4;
   localparam int ST = 8;
   localparam int TO = 20;
   localparam int MR = 2;

   localparam int PhRst    = 0;
   localparam int PhWait   = 1;
   localparam int PhStable = 2;
   localparam int PhRun    = 3;
   localparam int PhFail   = 4;

   localparam logic [15:0] ResetVec = {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0};

   logic       refclk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pll_locked = 1'b0;
   logic       relock_req = 1'b0;
   logic       pll_rst_o, pix_rst_n_o, ready_o, fail_o;
   logic [3:0] retry_cnt_o;
   logic [7:0] lock_loss_cnt_o;

   int n_vec = 0;
   int n_err = 0;

   // Model: phase plus the edge number at which it was entered
   int m_cyc, m_tentry, m_phase, m_retry, m_loss, m_s0, m_s1;

   pll_lock_supervisor #(
      .PLL_RST_CYCLES     (PR),
      .LOCK_STABLE_CYCLES (ST),
      .LOCK_TIMEOUT_CYCLES(TO),
      .MAX_RETRIES        (MR)
   ) dut (
      .refclk_i       (refclk),
      .rst_ni         (rst_n),
      .pll_locked_i   (pll_locked),
      .relock_req_i   (relock_req),
      .pll_rst_o      (pll_rst_o),
      .pix_rst_n_o    (pix_rst_n_o),
      .ready_o        (ready_o),
      .fail_o         (fail_o),
      .retry_cnt_o    (retry_cnt_o),
      .lock_loss_cnt_o(lock_loss_cnt_o)
   );

   always #10 refclk = ~refclk;

   function automatic logic [15:0] dut_vec();
      return {pll_rst_o, pix_rst_n_o, ready_o, fail_o, retry_cnt_o, lock_loss_cnt_o};
   endfunction

   function automatic logic [15:0] model_vec();
      return {m_phase == PhRst, m_phase == PhRun, m_phase == PhRun, m_phase == PhFail,
              4'(m_retry), 8'(m_loss)};
   endfunction

   task automatic model_reset();
      m_cyc = 0; m_tentry = 0; m_phase = PhRst; m_retry = 0; m_loss = 0; m_s0 = 0; m_s1 = 0;
   endtask

   task automatic model_step();
      int ls, e, nxt;
      ls = m_s1;
      m_s1 = m_s0;
      m_s0 = int'(pll_locked);
      m_cyc++;
      e = m_cyc - m_tentry;
      nxt = m_phase;
      case (m_phase)
         PhRst:    if (e == PR) nxt = PhWait;
         PhWait: begin
            if (ls == 1) nxt = PhStable;
            else if (e == TO) begin
               m_retry++;
               nxt = (m_retry == MR) ? PhFail : PhRst;
            end
         end
         PhStable: begin
            if (ls == 0) nxt = PhWait;
            else if (e == ST) begin nxt = PhRun; m_retry = 0; end
         end
         PhRun: begin
            if (ls == 0) begin nxt = PhRst; m_loss = (m_loss < 255) ? m_loss + 1 : 255; end
            else if (relock_req) nxt = PhRst;
         end
         default: if (relock_req) begin nxt = PhRst; m_retry = 0; end
      endcase
      if (nxt != m_phase) begin m_phase = nxt; m_tentry = m_cyc; end
   endtask

   task automatic tick();
      @(posedge refclk);
      model_step();
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      pll_locked = 1'b0;
      relock_req = 1'b0;
      model_reset();
      repeat (2) @(negedge refclk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #25;
      n_vec++;
      if (dut_vec() !== ResetVec) begin
         n_err++; $display("FAIL reset_values: got %h, expected %h", dut_vec(), ResetVec);
      end
      apply_reset();
   endtask

   task automatic test_lock_clean();
      int fall = -1, rdy = -1;
      apply_reset();
      pll_locked = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         tick();
         if (fall < 0 && !pll_rst_o) fall = c;
         if (rdy < 0 && ready_o) rdy = c;
      end
      n_vec++;
      if (fall != PR) begin n_err++; $display("FAIL clean_pllrst_fall: edge %0d, expected %0d", fall, PR); end
      n_vec++;
      if (rdy != 13) begin n_err++; $display("FAIL clean_ready_edge: edge %0d, expected 13", rdy); end
      n_vec++;
      if ({pix_rst_n_o, retry_cnt_o} !== 5'b1_0000) begin
         n_err++; $display("FAIL clean_run_outputs: got %b, expected 10000", {pix_rst_n_o, retry_cnt_o});
      end
   endtask

   task automatic test_timeout_fail();
      int rr = -1, fl = -1, fr = -1;
      bit hi_ok = 1'b1;
      apply_reset();
      for (int c = 1; c <= 60; c++) begin
         tick();
         if (rr < 0 && retry_cnt_o == 4'd1 && pll_rst_o) rr = c;
         if (fl < 0 && fail_o) begin fl = c; fr = int'(retry_cnt_o); end
         if (c >= 24 && c <= 27 && !pll_rst_o) hi_ok = 1'b0;
      end
      n_vec++;
      if (rr != 24) begin n_err++; $display("FAIL timeout_retry1_edge: edge %0d, expected 24", rr); end
      n_vec++;
      if (!hi_ok) begin n_err++; $display("FAIL timeout_pllrst_window: got low, expected high 24..27"); end
      n_vec++;
      if (fl != 48 || fr != MR) begin
         n_err++; $display("FAIL timeout_fail_edge: edge %0d retry %0d, expected 48 retry %0d", fl, fr, MR);
      end
      n_vec++;
      if (pll_rst_o !== 1'b0) begin n_err++; $display("FAIL fail_pllrst: got %b, expected 0", pll_rst_o); end
      relock_req = 1'b1;
      tick();
      relock_req = 1'b0;
      n_vec++;
      if ({pll_rst_o, fail_o, retry_cnt_o} !== 6'b10_0000) begin
         n_err++;
         $display("FAIL fail_rearm: got %b, expected 100000", {pll_rst_o, fail_o, retry_cnt_o});
      end
   endtask

   task automatic test_glitch();
      int rdy = -1;
      apply_reset();
      pll_locked = 1'b1;
      repeat (7) tick();
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      for (int c = 9; c <= 40; c++) begin
         tick();
         if (rdy < 0 && ready_o) rdy = c;
      end
      n_vec++;
      if (rdy != 19) begin n_err++; $display("FAIL glitch_ready_edge: edge %0d, expected 19", rdy); end
      n_vec++;
      if (retry_cnt_o !== 4'd0) begin n_err++; $display("FAIL glitch_retry: got %0d, expected 0", retry_cnt_o); end
   endtask

   task automatic test_lock_loss();
      int lat;
      apply_reset();
      pll_locked = 1'b1;
      for (int c = 0; c < 30 && !ready_o; c++) tick();
      for (int i = 1; i <= 257; i++) begin
         pll_locked = 1'b0;
         lat = 0;
         for (int c = 1; c <= 6; c++) begin
            tick();
            if (!pix_rst_n_o) begin lat = c; break; end
         end
         n_vec++;
         if (lat < 1 || lat > 3) begin n_err++; $display("FAIL loss_latency: %0d edges, expected 1..3", lat); end
         pll_locked = 1'b1;
         for (int c = 0; c < 40 && !ready_o; c++) tick();
         n_vec++;
         if (ready_o !== 1'b1) begin n_err++; $display("FAIL loss_relock_timeout: ready %b, expected 1", ready_o); end
         if (i == 3 || i == 255 || i == 257) begin
            n_vec++;
            if (int'(lock_loss_cnt_o) != ((i > 255) ? 255 : i)) begin
               n_err++; $display("FAIL loss_count: got %0d, expected %0d", lock_loss_cnt_o, (i > 255) ? 255 : i);
            end
         end
      end
   endtask

   task automatic test_relock();
      int hi = 0;
      apply_reset();
      pll_locked = 1'b1;
      for (int c = 0; c < 30 && !ready_o; c++) tick();
      relock_req = 1'b1;
      tick();
      relock_req = 1'b0;
      n_vec++;
      if ({pll_rst_o, ready_o} !== 2'b10) begin
         n_err++; $display("FAIL relock_enter: got %b, expected 10", {pll_rst_o, ready_o});
      end
      for (int c = 0; c < 10 && pll_rst_o; c++) begin hi++; tick(); end
      n_vec++;
      if (hi != PR) begin n_err++; $display("FAIL relock_pllrst_len: %0d cycles, expected %0d", hi, PR); end
      for (int c = 0; c < 30 && !ready_o; c++) tick();
      n_vec++;
      if ({ready_o, lock_loss_cnt_o} !== 9'h100) begin
         n_err++; $display("FAIL relock_return: got %h, expected 100", {ready_o, lock_loss_cnt_o});
      end
      pll_locked = 1'b0;
      tick();
      tick();
      relock_req = 1'b1;
      tick();
      relock_req = 1'b0;
      n_vec++;
      if ({pll_rst_o, lock_loss_cnt_o} !== 9'h101) begin
         n_err++; $display("FAIL relock_with_loss: got %h, expected 101", {pll_rst_o, lock_loss_cnt_o});
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      pll_locked = 1'b1;
      repeat (8) tick();
      n_vec++;
      if (pll_rst_o !== 1'b0) begin n_err++; $display("FAIL stable_precheck: pll_rst %b, expected 0", pll_rst_o); end
      #3 rst_n = 1'b0;
      #2;
      n_vec++;
      if (dut_vec() !== ResetVec) begin
         n_err++; $display("FAIL async_reset_stable: got %h, expected %h", dut_vec(), ResetVec);
      end
      apply_reset();
      repeat (50) tick();
      n_vec++;
      if (fail_o !== 1'b1) begin n_err++; $display("FAIL fail_precheck: fail %b, expected 1", fail_o); end
      #3 rst_n = 1'b0;
      #2;
      n_vec++;
      if (dut_vec() !== ResetVec) begin
         n_err++; $display("FAIL async_reset_fail: got %h, expected %h", dut_vec(), ResetVec);
      end
   endtask

   task automatic test_random();
      int seg = 0;
      apply_reset();
      for (int c = 0; c < 4000; c++) begin
         if (seg == 0) begin
            pll_locked = ($urandom_range(0, 3) != 0);
            seg = pll_locked ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 30));
         end
         seg--;
         relock_req = ($urandom_range(0, 30) == 0);
         tick();
         n_vec++;
         if (dut_vec() !== model_vec()) begin
            n_err++; $display("FAIL random_cycle%0d: got %h, expected %h", c, dut_vec(), model_vec());
         end
      end
      relock_req = 1'b0;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_lock_clean();
      test_timeout_fail();
      test_glitch();
      test_lock_loss();
      test_relock();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
